ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver. It synchronises ps2_clk and ps2_data, deframes 11-bit frames (start, 8 data bits LSB-first, odd parity, stop) and checks every frame. Good bytes are buffered in a FIFO with a valid/ready output, so the core or an MMIO keyboard register can drain codes at its own pace. Errors, overflow and an idle watchdog are reported to the consumer instead of being printed.

---
 rtl/ps2_rx_fifo.sv | 178 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, 11-bit frame checker, watchdog and byte FIFO.
// Optional macro PS2_BREAK_TAG_EN folds 0xF0 break prefixes into a brk flag on the next byte.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic [7:0]                  data,
`ifdef PS2_BREAK_TAG_EN
    output logic                        brk,
`endif
    output logic                        valid,
    input  logic                        ready,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    input  logic                        clr_overflow,
    output logic                        parity_err,
    output logic                        frame_err
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '0;
`ifdef PS2_BREAK_TAG_EN
    localparam int DW = 9;
`else
    localparam int DW = 8;
`endif

    typedef enum logic {IDLE, RECV} state_t;

    // Synchronisers reset high so reset release never looks like a falling edge
    logic [SYNC_STAGES-1:0] sync_clk, sync_data;
    logic sample, bit_in;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_clk  <= '1;
            sync_data <= '1;
        end else begin
            sync_clk  <= {sync_clk[SYNC_STAGES-2:0], ps2_clk};
            sync_data <= {sync_data[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign sample = sync_clk[SYNC_STAGES-1] & ~sync_clk[SYNC_STAGES-2];
    assign bit_in = sync_data[SYNC_STAGES-1];

    state_t         state, state_n;
    logic [3:0]     bitcnt, bitcnt_n;
    logic [9:0]     frame, frame_n;
    logic [WDW-1:0] wdog, wdog_n;
    logic           push_req, perr_n, ferr_n;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            bitcnt <= '0;
            frame  <= '0;
            wdog   <= '0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            frame  <= frame_n;
            wdog   <= wdog_n;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        frame_n  = frame;
        wdog_n   = wdog;
        push_req = 1'b0;
        perr_n   = 1'b0;
        ferr_n   = 1'b0;
        case (state)
            IDLE: begin
                wdog_n = '0;
                if (sample) begin
                    frame_n[0] = bit_in;
                    bitcnt_n   = 4'd1;
                    state_n    = RECV;
                end
            end
            RECV: begin
                if (sample) begin
                    wdog_n = '0;
                    if (bitcnt == 4'd10) begin
                        // Stop bit is checked live, it is never stored
                        state_n  = IDLE;
                        bitcnt_n = '0;
                        if (frame[0] || !bit_in) ferr_n = 1'b1;
                        else if (!(^frame[9:1])) perr_n = 1'b1;
                        else push_req = 1'b1;
                    end else begin
                        frame_n[bitcnt] = bit_in;
                        bitcnt_n        = bitcnt + 4'd1;
                    end
                end else if (TIMEOUT_CYCLES != 0 && wdog == WD_LAST) begin
                    state_n  = IDLE;
                    bitcnt_n = '0;
                    wdog_n   = '0;
                    ferr_n   = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wdog_n = wdog + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [7:0]    rx_byte;
    logic          push;
    logic [DW-1:0] push_word;
    assign rx_byte = frame[8:1];

`ifdef PS2_BREAK_TAG_EN
    logic brk_pend;
    assign push      = push_req && (rx_byte != 8'hF0);
    assign push_word = {brk_pend, rx_byte};

    always_ff @(posedge clk) begin
        if (!resetn)       brk_pend <= 1'b0;
        else if (push_req) brk_pend <= (rx_byte == 8'hF0);
    end
`else
    assign push      = push_req;
    assign push_word = rx_byte;
`endif

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, full, wr_en;
    logic [DW-1:0] head;

    assign valid = (count != '0);
    assign pop   = valid & ready;
    assign full  = (count == CW'(FIFO_DEPTH));
    // A push into a full FIFO still lands when the head leaves in the same cycle
    assign wr_en = push & (~full | pop);
    assign head  = mem[rd_ptr];
    assign data  = valid ? head[7:0] : 8'h00;
`ifdef PS2_BREAK_TAG_EN
    assign brk   = valid ? head[8] : 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
            else if (clr_overflow)    overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed frames plus random traffic against a queue-based frame model.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int SYNC  = 3;
    localparam int TMO   = 200;
    localparam int HALF  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 0, resetn = 0, ps2_clk = 1, ps2_data = 1, ready = 0, clr_overflow = 0;
    logic [7:0]    data;
    logic          valid, overflow, parity_err, frame_err;
    logic [CW-1:0] count;
`ifdef PS2_BREAK_TAG_EN
    logic          brk;
`endif

    int n_chk = 0, n_fail = 0;

    ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data(data),
`ifdef PS2_BREAK_TAG_EN
        .brk(brk),
`endif
        .valid(valid), .ready(ready), .count(count), .overflow(overflow),
        .clr_overflow(clr_overflow), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: each completed frame becomes an event at the clk edge where it must take effect
    typedef struct { int due; int kind; logic [7:0] b; } ev_t;  // kind 0 good, 1 parity, 2 framing
    ev_t        evq[$];
    ev_t        m_e;
    logic [8:0] mq[$];
    logic [8:0] m_w;
    bit         m_ovf = 0, m_pend = 0, m_pe = 0, m_fe = 0, m_pop, m_push;
    int         cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        m_pe = 0;
        m_fe = 0;
        if (!resetn) begin
            mq.delete();
            evq.delete();
            m_ovf  = 0;
            m_pend = 0;
        end else begin
            m_pop  = ready && mq.size() > 0;
            m_push = 0;
            m_w    = '0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
                m_e = evq.pop_front();
                if (m_e.kind == 1) m_pe = 1;
                else if (m_e.kind == 2) m_fe = 1;
                else begin
`ifdef PS2_BREAK_TAG_EN
                    if (m_e.b == 8'hF0) m_pend = 1;
                    else begin
                        m_push = 1;
                        m_w    = {m_pend, m_e.b};
                        m_pend = 0;
                    end
`else
                    m_push = 1;
                    m_w    = {1'b0, m_e.b};
`endif
                end
            end
            if (m_push && mq.size() == DEPTH && !m_pop) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
            if (m_pop) void'(mq.pop_front());
            if (m_push && mq.size() < DEPTH) mq.push_back(m_w);
        end
    end

    bit chk_en = 0;
    int pe_cnt = 0, fe_cnt = 0;

    always @(negedge clk) begin
        pe_cnt <= pe_cnt + int'(parity_err);
        fe_cnt <= fe_cnt + int'(frame_err);
    end

    always @(negedge clk) if (chk_en) begin
        check("valid", valid, mq.size() != 0);
        check("count", count, mq.size());
        check("data", data, (mq.size() != 0) ? mq[0][7:0] : 8'h00);
        check("overflow", overflow, m_ovf);
        check("parity_err", parity_err, m_pe);
        check("frame_err", frame_err, m_fe);
`ifdef PS2_BREAK_TAG_EN
        check("brk", brk, (mq.size() != 0) ? mq[0][8] : 1'b0);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame (or its first nbits). Falling edges are placed just after a clk edge,
    // so the synchronised sample acts SYNC edges later.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_start,
                              input bit bad_stop, input int nbits, input bit pop_at_stop,
                              input bit expect_wd);
        logic [10:0] f;
        ev_t e;
        f[0]    = bad_start;
        f[8:1]  = b;
        f[9]    = ~(^b) ^ bad_par;
        f[10]   = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) step();
            ps2_clk = 0;
            e.b = b;
            if (i == 10) begin
                e.due  = cyc + SYNC;
                e.kind = (f[0] != 1'b0 || f[10] != 1'b1) ? 2 : ((^f[9:1]) == 1'b0) ? 1 : 0;
                evq.push_back(e);
            end else if (i == nbits - 1 && expect_wd) begin
                e.due  = cyc + SYNC + TMO;
                e.kind = 2;
                evq.push_back(e);
            end
            if (i == 10 && pop_at_stop) begin
                repeat (SYNC - 1) step();
                ready = 1;
                step();
                ready = 0;
                repeat (HALF - SYNC) step();
            end else begin
                repeat (HALF) step();
            end
            ps2_clk = 1;
        end
        ps2_data = 1;
        repeat (HALF) step();
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 0, 0, 0, 11, 0, 0);
    endtask

    logic [8:0] drained[$];

    task automatic drain();
        drained.delete();
        ready = 1;
        for (int k = 0; k < DEPTH + 4; k++) begin
            @(negedge clk);
            if (!valid) break;
`ifdef PS2_BREAK_TAG_EN
            drained.push_back({brk, data});
`else
            drained.push_back({1'b0, data});
`endif
            step();
        end
        ready = 0;
        step();
    endtask

    int  pe0, fe0;
    bit  rdone;
    logic [7:0] rb;
    int  rr;

    initial begin
        step();
        chk_en = 1;
        repeat (2) step();
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_data", data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_errs", {parity_err, frame_err}, 0);
        resetn = 1;
        repeat (2) step();

        // Single good frame, then pop it
        good(8'h1C);
        check("t1_valid", valid, 1);
        check("t1_data", data, 8'h1C);
        check("t1_count", count, 1);
        check("t1_no_err", pe_cnt + fe_cnt, 0);
        ready = 1;
        step();
        ready = 0;
        step();
        check("t1_popped", {valid, count}, 0);

        // Parity and framing errors
        pe0 = pe_cnt;
        fe0 = fe_cnt;
        send_frame(8'h1C, 1, 0, 0, 11, 0, 0);
        check("t2_perr", pe_cnt - pe0, 1);
        check("t2_perr_count", count, 0);
        send_frame(8'h32, 0, 1, 0, 11, 0, 0);
        check("t2_ferr", fe_cnt - fe0, 1);
        check("t2_ferr_no_perr", pe_cnt - pe0, 1);
        check("t2_ferr_count", count, 0);

        // Overflow and in-order drain
        for (int i = 1; i <= 9; i++) good(8'(i));
        check("t3_count", count, 8);
        check("t3_overflow", overflow, 1);
        drain();
        check("t3_drain_n", drained.size(), 8);
        for (int i = 0; i < 8 && i < drained.size(); i++) check("t3_order", drained[i], 9'(i + 1));
        clr_overflow = 1;
        step();
        clr_overflow = 0;
        step();
        check("t3_clr", overflow, 0);

        // Push and pop on the same edge while full
        for (int i = 1; i <= 8; i++) good(8'(i));
        check("t4_full", count, 8);
        send_frame(8'h0A, 0, 0, 0, 11, 1, 0);
        check("t4_count", count, 8);
        check("t4_overflow", overflow, 0);
        drain();
        check("t4_drain_n", drained.size(), 8);
        if (drained.size() == 8) begin
            check("t4_first", drained[0], 9'h002);
            check("t4_last", drained[7], 9'h00A);
        end

        // Watchdog expiry, then recovery
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        send_frame(8'h55, 0, 0, 0, 5, 0, 1);
        repeat (TMO + 20) step();
        check("t5_wd_ferr", fe_cnt - fe0, 1);
        good(8'h32);
        check("t5_wd_data", data, 8'h32);
        check("t5_wd_count", count, 1);
        drain();

        // Reset mid-frame
        fe0 = fe_cnt;
        send_frame(8'h77, 0, 0, 0, 5, 0, 0);
        resetn = 0;
        repeat (2) step();
        resetn = 1;
        repeat (2) step();
        good(8'h32);
        check("t5_rst_data", data, 8'h32);
        check("t5_rst_count", count, 1);
        check("t5_rst_errs", (fe_cnt - fe0) + (pe_cnt - pe0), 0);
        drain();

        // Break prefix
        good(8'hF0);
        good(8'h1C);
`ifdef PS2_BREAK_TAG_EN
        check("t6_count", count, 1);
        check("t6_data", data, 8'h1C);
        check("t6_brk", brk, 1);
        drain();
`else
        check("t6_count", count, 2);
        drain();
        check("t6_n", drained.size(), 2);
        if (drained.size() == 2) begin
            check("t6_first", drained[0], 9'h0F0);
            check("t6_second", drained[1], 9'h01C);
        end
`endif

        // Random traffic with random errors, consumer stalls and overflow clears
        rdone = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    rb = 8'($urandom);
                    if ($urandom % 8 == 0) rb = 8'hF0;
                    rr = int'($urandom % 10);
                    send_frame(rb, rr == 0, rr == 1, rr == 2, 11, 0, 0);
                    repeat ($urandom % 6) step();
                end
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    ready        = ($urandom % 10) < 3;
                    clr_overflow = ($urandom % 16) == 0;
                    step();
                end
                ready        = 0;
                clr_overflow = 0;
            end
        join
        drain();
        check("end_empty", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
